// File: rtl/pair_pack_arbiter_pkg.sv
// Shared types and defaults for the two-requester byte-pair packer.
// Holds the FSM encoding, default sizing and the assertion message format.
package pair_pack_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int    DEF_W       = 8;
  localparam int    DEF_TIMEOUT = 15;
  localparam string ASSERT_MSG  = "ASSERTION FAILED: %s";
endpackage

// File: rtl/pair_pack_arbiter_rr_pick2.sv
// Two-input round-robin picker: prefers the requester that was not served last.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant,
  output logic       any
);
  assign any   = |valid;
  assign grant = valid[~last] ? ~last : last;
endmodule

// File: rtl/pair_pack_arbiter.sv
// Shares one hi/lo byte-pair packer between two requesters, round-robin,
// with a watchdog that aborts a grant stuck waiting for its low byte.
module pair_pack_arbiter
  import pair_pack_arbiter_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     req_valid,
  input  logic [2*W-1:0] req_data,
  output logic [1:0]     req_ready,
  output logic           out_valid,
  output logic [2*W-1:0] out_data,
  output logic           out_src,
  input  logic           out_ready,
  output logic           err,
  input  logic           err_clr
);
  state_t         state;
  logic           g;
  logic           last;
  logic           pick;
  logic           any;
  logic [W-1:0]   hi;
  logic [7:0]     timer;
  logic [8:0]     timer_inc;
  logic           g_valid;
  logic [W-1:0]   g_byte;
  logic           abort;

  rr_pick2 u_pick (
    .valid (req_valid),
    .last  (last),
    .grant (pick),
    .any   (any)
  );

  assign g_valid   = req_valid[g];
  assign g_byte    = g ? req_data[2*W-1:W] : req_data[W-1:0];
  assign timer_inc = {1'b0, timer} + 9'd1;
  // Abort on the edge where this wait cycle would bring the timer to TIMEOUT.
  assign abort     = (state == LO) && !g_valid && (timer_inc >= 9'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      g         <= 1'b0;
      hi        <= '0;
      timer     <= '0;
      req_ready <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (abort)        err <= 1'b1;
      else if (err_clr) err <= 1'b0;

      case (state)
        IDLE: if (any) begin
          g         <= pick;
          req_ready <= pick ? 2'b10 : 2'b01;
          state     <= HI;
        end
        HI: if (g_valid) begin
          hi    <= g_byte;
          timer <= '0;
          state <= LO;
        end
        LO: if (g_valid) begin
          out_data  <= {hi, g_byte};
          out_src   <= g;
          out_valid <= 1'b1;
          req_ready <= '0;
          state     <= OUT;
        end else begin
          timer <= timer_inc[8] ? timer : timer_inc[7:0];
          if (abort) begin
            last      <= g;
            hi        <= '0;
            req_ready <= '0;
            state     <= IDLE;
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          last      <= g;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  logic prev_err;
  logic prev_abort;
  // err may only rise as the result of a watchdog abort on the previous edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_err   <= 1'b0;
      prev_abort <= 1'b0;
    end else begin
      if (err && !prev_err)
        assert (prev_abort)
          else $error("%s", $sformatf(ASSERT_MSG, "err rose without an LO timeout"));
      prev_err   <= err;
      prev_abort <= abort;
    end
  end
`endif
endmodule

// File: tb/tb_pair_pack_arbiter.sv
// Randomized bench: per-requester byte streams feed the DUT; every output word
// is checked against the pairs each requester queued, plus directed corner cases.
module tb_pair_pack_arbiter;
  import pair_pack_arbiter_pkg::*;
  localparam int W  = 8;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     req_valid;
  logic [2*W-1:0] req_data;
  logic [1:0]     req_ready;
  logic           out_valid;
  logic [2*W-1:0] out_data;
  logic           out_src;
  logic           out_ready;
  logic           err;
  logic           err_clr;

  pair_pack_arbiter #(.W(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_words = 0;
  int last_acc_cyc = 0;
  int acc_gap = 0;
  logic last_acc_src = 1'b0;

  // Requester byte streams and the words each stream must produce, in order.
  logic [W-1:0]   q0[$];
  logic [W-1:0]   q1[$];
  logic [2*W-1:0] e0[$];
  logic [2*W-1:0] e1[$];
  bit   gaps = 0;
  bit   ordy_rnd = 0;
  logic ordy = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_pair(input int src, input logic [W-1:0] h, input logic [W-1:0] l);
    if (src == 0) begin q0.push_back(h); q0.push_back(l); e0.push_back({h, l}); end
    else          begin q1.push_back(h); q1.push_back(l); e1.push_back({h, l}); end
  endtask

  task automatic drive();
    req_valid[0] = (q0.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
    req_valid[1] = (q1.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
    req_data[W-1:0]   = (q0.size() > 0) ? q0[0] : W'($urandom);
    req_data[2*W-1:W] = (q1.size() > 0) ? q1[0] : W'($urandom);
    out_ready = ordy_rnd ? 1'($urandom_range(0, 1)) : ordy;
  endtask

  // One clock: drive, observe handshakes at the edge, score the results.
  task automatic step();
    logic [1:0]     hs;
    logic           oh;
    logic           ov;
    logic [2*W-1:0] od;
    logic           os;
    logic [2*W-1:0] ex;
    drive();
    hs = req_valid & req_ready;
    ov = out_valid;
    oh = out_valid & out_ready;
    od = out_data;
    os = out_src;
    @(posedge clk); #1;
    cyc++;
    if (hs[0]) void'(q0.pop_front());
    if (hs[1]) void'(q1.pop_front());
    if (oh) begin
      n_words++;
      acc_gap      = cyc - last_acc_cyc;
      last_acc_cyc = cyc;
      last_acc_src = os;
      chk("word_pending", 32'((os ? e1.size() : e0.size()) > 0), 32'd1);
      if ((os ? e1.size() : e0.size()) > 0) begin
        ex = os ? e1.pop_front() : e0.pop_front();
        chk(os ? "word_src1" : "word_src0", 32'(od), 32'(ex));
      end
    end else if (ov) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(od));
      chk("hold_src", 32'(out_src), 32'(os));
    end
    chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    chk("ready_in_out", 32'(out_valid && (req_ready != 2'b00)), 32'd0);
  endtask

  task automatic drain(input int bound);
    for (int n = 0; n < bound && (q0.size() + q1.size() + e0.size() + e1.size() > 0 || out_valid); n++)
      step();
    chk("drain_done", 32'(q0.size() + q1.size() + e0.size() + e1.size()) + 32'(out_valid), 32'd0);
  endtask

  int   n;
  int   w0;
  int   wprev;
  logic psrc;
  logic [2*W-1:0] held;

  initial begin
    reset = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b1;

    // Single requester, minimum latency.
    ordy = 1'b1;
    push_pair(0, 8'hAB, 8'hCD);
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    chk("single_latency", 32'(n), 32'd3);
    chk("single_data", 32'(out_data), 32'hABCD);
    chk("single_src", 32'(out_src), 32'd0);
    step();
    chk("single_held_1", 32'(out_valid), 32'd0);

    // Contention: both requesters always valid; last served was 0, so 1 goes first.
    for (int k = 0; k < 3; k++) begin
      push_pair(0, 8'h11, 8'h22);
      push_pair(1, 8'h33, 8'h44);
    end
    w0 = n_words; wprev = n_words; psrc = 1'b0;
    for (int k = 0; k < 60 && (e0.size() + e1.size() > 0); k++) begin
      step();
      if (n_words != wprev) begin
        if (n_words - w0 == 1) chk("contend_first_src", 32'(last_acc_src), 32'd1);
        else begin
          chk("contend_alt_src", 32'(last_acc_src), 32'(!psrc));
          chk("contend_gap", 32'(acc_gap), 32'd4);
        end
        psrc = last_acc_src; wprev = n_words;
      end
    end
    chk("contend_words", 32'(n_words - w0), 32'd6);

    // Backpressure: last served was 0, so requester 1 is granted first.
    ordy = 1'b0;
    push_pair(0, 8'h12, 8'h34);
    push_pair(1, 8'h56, 8'h78);
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    chk("bp_src", 32'(out_src), 32'd1);
    held = out_data;
    chk("bp_data", 32'(held), 32'h5678);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_ready_low", 32'(req_ready), 32'd0);
      chk("bp_stable", 32'(out_data), 32'(held));
    end
    ordy = 1'b1;
    step();
    chk("bp_accepted", 32'(out_valid), 32'd0);
    drain(30);

    // Timeout: lone hi byte from requester 1, low byte never comes.
    q1.push_back(8'h5A);
    n = 0;
    while (q1.size() > 0 && n < 10) begin step(); n++; end
    n = 0;
    while (!err && n < 40) begin
      step(); n++;
      chk("to_no_out", 32'(out_valid), 32'd0);
    end
    chk("to_latency", 32'(n), 32'(TO));
    chk("to_idle_ready", 32'(req_ready), 32'd0);
    push_pair(1, 8'h03, 8'h04);
    push_pair(0, 8'h01, 8'h02);
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    chk("to_next_src", 32'(out_src), 32'd0);
    drain(30);
    chk("err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr_pulse", 32'(err), 32'd0);

    // Second timeout with err_clr held: the set must win on the abort edge.
    err_clr = 1'b1;
    q1.push_back(8'h66);
    n = 0;
    while (q1.size() > 0 && n < 10) begin step(); n++; end
    n = 0;
    while (!err && n < 40) begin step(); n++; end
    chk("to2_set_wins", 32'(n), 32'(TO));
    step();
    chk("to2_clr_after", 32'(err), 32'd0);
    err_clr = 1'b0;

    // Reset in LO after hi byte 0x77.
    q0.push_back(8'h77);
    n = 0;
    while (q0.size() > 0 && n < 10) begin step(); n++; end
    step(); step();
    chk("mid_ready_before", 32'(req_ready), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    push_pair(1, 8'h01, 8'h02);
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    chk("mid_fresh_data", 32'(out_data), 32'h0102);
    chk("mid_fresh_src", 32'(out_src), 32'd1);
    drain(30);

    // Randomized traffic with valid gaps and random consumer stalls.
    gaps = 1; ordy_rnd = 1;
    w0 = n_words;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 5) == 0)
        push_pair(int'($urandom_range(0, 1)), W'($urandom), W'($urandom));
      step();
    end
    drain(400);
    chk("rand_some_words", 32'(n_words - w0 > 20), 32'd1);
    chk("rand_no_err", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end
endmodule
